// File: rtl/wave_rom_sequencer.sv
// wave_rom_sequencer: phase-accumulator sequencer driving a registered waveform ROM, burst or continuous.
// Optional half-amplitude output when WAVE_SEQ_HALF_AMP_EN is defined (adds input amp_half).
module wave_rom_sequencer #(
   parameter int ADDR_W  = 10,
   parameter int PHASE_W = 16,
   parameter int DATA_W  = 8,
   parameter int CNT_W   = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               stop,
   input  logic [PHASE_W-1:0] step,
   input  logic [CNT_W-1:0]   periods,
   output logic [ADDR_W-1:0]  rom_addr,
   input  logic [DATA_W-1:0]  rom_data,
`ifdef WAVE_SEQ_HALF_AMP_EN
   input  logic               amp_half,
`endif
   output logic [DATA_W-1:0]  sample,
   output logic               sample_valid,
   output logic               busy,
   output logic               done
);
   typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
   localparam logic [DATA_W-1:0] MID = {1'b1, {(DATA_W-1){1'b0}}};
   state_t state, state_nx;
   logic [PHASE_W-1:0] acc, step_q;
   logic [PHASE_W:0]   sum;
   logic [CNT_W-1:0]   periods_q, period_cnt;
   logic               carry, last, data_v;
`ifdef WAVE_SEQ_HALF_AMP_EN
   localparam logic [DATA_W-1:0] QUARTER = {2'b01, {(DATA_W-2){1'b0}}};
   logic amp_q;
`endif
   assign sum      = {1'b0, acc} + {1'b0, step_q};
   assign carry    = sum[PHASE_W];
   assign last     = carry && periods_q != '0 && period_cnt + CNT_W'(1) == periods_q;
   assign rom_addr = acc[PHASE_W-1 -: ADDR_W];
   assign busy     = state != IDLE;
   // data_v marks rom_data carrying the last issued address; once it clears the pipe is empty
   assign done     = state == FLUSH && !data_v;
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = RUN;
         RUN:     if (stop || last) state_nx = FLUSH;
         FLUSH:   if (!data_v) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         acc          <= '0;
         step_q       <= '0;
         periods_q    <= '0;
         period_cnt   <= '0;
         data_v       <= 1'b0;
         sample_valid <= 1'b0;
         sample       <= MID;
`ifdef WAVE_SEQ_HALF_AMP_EN
         amp_q        <= 1'b0;
`endif
      end else begin
         state <= state_nx;
         if (state == IDLE && start) begin
            step_q     <= step;
            periods_q  <= periods;
            acc        <= '0;
            period_cnt <= '0;
         end else if (state == RUN) begin
            acc <= sum[PHASE_W-1:0];
            if (carry) period_cnt <= period_cnt + CNT_W'(1);
         end
         data_v       <= state == RUN;
         sample_valid <= data_v;
`ifdef WAVE_SEQ_HALF_AMP_EN
         amp_q <= amp_half;
         if (data_v) sample <= amp_q ? (rom_data >> 1) + QUARTER : rom_data;
`else
         if (data_v) sample <= rom_data;
`endif
      end
   end
endmodule

// File: tb/tb_wave_rom_sequencer.sv
// tb_wave_rom_sequencer: directed bench for wave_rom_sequencer with a behavioural registered ROM.
// Define WAVE_SEQ_HALF_AMP_EN to also exercise the half-amplitude build.
module tb_wave_rom_sequencer;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic [15:0] step = '0;
   logic [7:0]  periods = '0;
   logic [9:0]  rom_addr;
   logic [7:0]  rom_data = '0;
   logic [7:0]  sample;
   logic        sample_valid, busy, done;
   logic        amp_half = 1'b0;
   int          n_checks = 0;
   int          n_fail = 0;
   int          done_cnt = 0;
   int          d0;
   logic [7:0]  q[$];

   wave_rom_sequencer dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .step(step), .periods(periods),
      .rom_addr(rom_addr), .rom_data(rom_data),
`ifdef WAVE_SEQ_HALF_AMP_EN
      .amp_half(amp_half),
`endif
      .sample(sample), .sample_valid(sample_valid), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] rom_fn(input logic [9:0] a);
      return a[7:0] ^ {a[9:8], 6'b0};
   endfunction

   always @(posedge clk) rom_data <= rom_fn(rom_addr);

   always @(negedge clk) begin
      if (sample_valid) q.push_back(sample);
      if (done) done_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic go(input logic [15:0] st, input logic [7:0] per);
      q.delete();
      d0 = done_cnt;
      step = st;
      periods = per;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   function automatic logic [9:0] exp_addr(input int i, input logic [15:0] st);
      logic [31:0] p;
      p = i * st;
      return p[15:6];
   endfunction

   task automatic check_q(input string tag, input int n, input logic [15:0] st, input bit half);
      logic [7:0] e;
      check({tag, " nsamples"}, q.size(), n);
      for (int i = 0; i < n && i < q.size(); i++) begin
         e = rom_fn(exp_addr(i, st));
         if (half) e = (e >> 1) + 8'h40;
         check({tag, " sample"}, q[i], e);
      end
   endtask

   initial begin
      tick();
      tick();
      check("rst sample", sample, 8'h80);
      check("rst addr", rom_addr, 0);
      check("rst busy", busy, 0);
      check("rst valid", sample_valid, 0);
      check("rst done", done, 0);
      rst_n = 1'b1;
      tick();

      // T2: three periods of four addresses
      go(16'h4000, 8'd3);
      for (int i = 0; i < 12; i++) begin
         check("t2 addr", rom_addr, (i % 4) * 256);
         check("t2 busy", busy, 1);
         tick();
      end
      check("t2 done early", done, 0);
      tick();
      check("t2 done", done, 1);
      tick();
      check("t2 idle", busy, 0);
      check("t2 done cnt", done_cnt - d0, 1);
      check_q("t2", 12, 16'h4000, 0);

      // T3: continuous, stopped on the 100th address
      go(16'h0040, 8'd0);
      for (int i = 0; i < 100; i++) begin
         check("t3 addr", rom_addr, i);
         if (i == 99) stop = 1'b1;
         tick();
      end
      stop = 1'b0;
      check("t3 done early", done, 0);
      tick();
      check("t3 done", done, 1);
      tick();
      check("t3 idle", busy, 0);
      check("t3 done cnt", done_cnt - d0, 1);
      check_q("t3", 100, 16'h0040, 0);

      // T4: start with new step while busy is ignored
      go(16'h4000, 8'd2);
      for (int i = 0; i < 8; i++) begin
         check("t4 addr", rom_addr, (i % 4) * 256);
         if (i == 3) begin
            start = 1'b1;
            step = 16'h1000;
            periods = 8'd5;
         end else start = 1'b0;
         tick();
      end
      tick();
      check("t4 done", done, 1);
      for (int i = 0; i < 4; i++) tick();
      check("t4 idle", busy, 0);
      check("t4 done cnt", done_cnt - d0, 1);
      check_q("t4", 8, 16'h4000, 0);

      // T5: start+stop together in IDLE, then stop on the final carry
      stop = 1'b1;
      go(16'h8000, 8'd1);
      stop = 1'b0;
      check("t5 addr0", rom_addr, 0);
      check("t5 busy", busy, 1);
      tick();
      check("t5 addr1", rom_addr, 512);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      check("t5 flush", busy, 1);
      tick();
      check("t5 done", done, 1);
      for (int i = 0; i < 4; i++) tick();
      check("t5 idle", busy, 0);
      check("t5 done cnt", done_cnt - d0, 1);
      check_q("t5", 2, 16'h8000, 0);

      // T1: reset mid-run discards everything, no done
      go(16'h4000, 8'd0);
      for (int i = 0; i < 5; i++) tick();
      check("t1 running", busy, 1);
      rst_n = 1'b0;
      #1;
      check("t1 sample", sample, 8'h80);
      check("t1 addr", rom_addr, 0);
      check("t1 busy", busy, 0);
      check("t1 valid", sample_valid, 0);
      check("t1 done", done, 0);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      check("t1 still idle", busy, 0);
      check("t1 no done", done_cnt - d0, 0);

`ifdef WAVE_SEQ_HALF_AMP_EN
      // T6: half amplitude about midscale
      amp_half = 1'b1;
      go(16'h3FC0, 8'd0);
      for (int i = 0; i < 4; i++) begin
         if (i == 3) stop = 1'b1;
         tick();
      end
      stop = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      check("t6 done cnt", done_cnt - d0, 1);
      check_q("t6", 4, 16'h3FC0, 1);
      if (q.size() >= 2) begin
         check("t6 zero", q[0], 8'h40);
         check("t6 ff", q[1], 8'hBF);
      end
      amp_half = 1'b0;
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
